// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified memory port arbiter
package mem_arb_pkg;

    // Transaction sequencing: one grant walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Which requester owns the transaction currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// rtl/mem_port_arbiter_lat_counter.sv - loadable down-counter timing the memory read latency
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   load_i    load LOAD_VAL into the count
//   dec_i     decrement the count (stops at zero)
//   done_o    high while the count is 1, i.e. the final cycle of the wait
module arb_lat_counter #(
    parameter int WIDTH    = 2,
    parameter int LOAD_VAL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WIDTH'(LOAD_VAL);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count is loaded at the end of ISSUE, so the first WAIT cycle sees
    // LOAD_VAL and the cycle holding valid read data sees 1.
    assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and load/store
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (held until if_ready) and pc
//   if_rdata/if_ready              fetched instruction and one-cycle completion pulse
//   d_req_rd/d_req_wr              load/store request (held until d_ready); both high = store
//   d_addr/d_wdata/d_func3         data address, store data, access size
//   d_rdata/d_ready                load data and one-cycle completion pulse
//   stall_if/stall_mem             combinational stall terms for the hazard unit
//   m_en/m_we/m_addr/m_wdata/m_func3  registered memory-side controls
//   m_rdata                        memory read data, valid MEM_LAT cycles after m_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int MAX_DSTALL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_func3,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_func3,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam int STV_W = $clog2(MAX_DSTALL + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(MAX_DSTALL);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              m_en_q, m_en_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [2:0]        m_func3_q, m_func3_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;

    logic cnt_load, cnt_dec, cnt_done;
    logic d_any, fetch_wins;

    arb_lat_counter #(
        .WIDTH   (CNT_W),
        .LOAD_VAL(MEM_LAT)
    ) u_lat_counter (
        .clk   (clk),
        .rst   (rst),
        .load_i(cnt_load),
        .dec_i (cnt_dec),
        .done_o(cnt_done)
    );

    assign d_any = d_req_rd | d_req_wr;
    // Data has priority unless fetch has already lost MAX_DSTALL grants in a row.
    assign fetch_wins = if_req & (~d_any | (starve_q == STV_MAX));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_func3_d  = m_func3_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req | d_any) begin
                    // m_en/m_we are set on entry so they are high exactly in ISSUE.
                    state_d = ST_ISSUE;
                    m_en_d  = 1'b1;
                    if (fetch_wins) begin
                        owner_d   = OWN_IF;
                        m_addr_d  = if_addr;
                        m_wdata_d = '0;
                        m_func3_d = FUNCT3_WORD;
                        starve_d  = '0;
                    end else begin
                        owner_d   = OWN_D;
                        m_we_d    = d_req_wr;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_func3_d = d_func3;
                        if (if_req && (starve_q != STV_MAX)) begin
                            starve_d = starve_q + STV_W'(1);
                        end
                    end
                end
            end
            ST_ISSUE: begin
                cnt_load = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_done) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = m_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = m_rdata;
                        d_ready_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            starve_q   <= '0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_func3_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_func3_q  <= m_func3_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
        end
    end

    assign m_en     = m_en_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_func3  = m_func3_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign if_ready = if_ready_q;
    assign d_ready  = d_ready_q;

    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_any & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req_rd, d_req_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [2:0]    d_func3;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          stall_if, stall_mem;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [2:0]    m_func3;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DSTALL(MAXD)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_func3(d_func3), .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_func3(m_func3), .m_rdata(m_rdata)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] mem    [logic [31:0]];
    logic [31:0] shadow [logic [31:0]];
    logic [31:0] rd_due [int];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd_shadow(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_word(a);
    endfunction

    // Read data is presented only in its due cycle; every other cycle is noise.
    always @(negedge clk) begin
        if (rd_due.exists(cyc)) begin
            m_rdata = rd_due[cyc];
            rd_due.delete(cyc);
        end else begin
            m_rdata = $urandom;
        end
        if (m_en && !rst) begin
            if (m_we) mem[m_addr] = m_wdata;
            else rd_due[cyc + LAT] = mem.exists(m_addr) ? mem[m_addr] : init_word(m_addr);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        own_d;
    } iss_t;

    typedef struct {
        int          cyc;
        logic        own_d;
        logic        is_st;
        logic [31:0] data;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   free_at = 0;
    int   starve  = 0;

    // One transaction costs LAT+3 cycles; a request seen on a free cycle c
    // issues at c+1 and completes at c+2+LAT.
    always @(posedge clk) begin : model_step
        iss_t ni;
        rsp_t nr;
        bit   dreq, fw;
        if (rst) begin
            iss_q.delete();
            rsp_q.delete();
            starve  = 0;
            free_at = cyc + 1;
        end else if (cyc >= free_at && (if_req || d_req_rd || d_req_wr)) begin
            dreq = d_req_rd || d_req_wr;
            fw   = if_req && (!dreq || starve == MAXD);
            if (fw) begin
                starve = 0;
                ni = '{cyc + 1, 1'b0, if_addr, 32'h0, 3'b010, 1'b0};
                nr = '{cyc + 2 + LAT, 1'b0, 1'b0, rd_shadow(if_addr)};
            end else begin
                if (if_req) starve = (starve + 1 > MAXD) ? MAXD : starve + 1;
                ni = '{cyc + 1, d_req_wr, d_addr, d_wdata, d_func3, 1'b1};
                nr = '{cyc + 2 + LAT, 1'b1, d_req_wr, rd_shadow(d_addr)};
                if (d_req_wr) shadow[d_addr] = d_wdata;
            end
            iss_q.push_back(ni);
            rsp_q.push_back(nr);
            free_at = cyc + 3 + LAT;
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;
    bit          d_known      = 1'b1;
    bit          log_q[$];

    always @(negedge clk) begin : monitor
        iss_t mi;
        rsp_t mr;
        bit   e_en, e_ir, e_dr;
        if (rst) begin
            check("reset_ctl", 64'({m_en, m_we, if_ready, d_ready, m_func3}), 64'(0));
            check("reset_maddr", 64'(m_addr), 64'(0));
            check("reset_mwdata", 64'(m_wdata), 64'(0));
            check("reset_rdata", 64'({if_rdata, d_rdata}), 64'(0));
            exp_if_rdata = '0;
            exp_d_rdata  = '0;
            d_known      = 1'b1;
            while (iss_q.size() > 0 && iss_q[0].cyc <= cyc) iss_q.delete(0);
            while (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) rsp_q.delete(0);
        end else begin
            e_en = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
            check("m_en", 64'({m_en, m_we & ~m_en}), 64'({e_en, 1'b0}));
            if (e_en) begin
                mi = iss_q.pop_front();
                check("m_addr", 64'(m_addr), 64'(mi.addr));
                check("m_we", 64'(m_we), 64'(mi.we));
                check("m_func3", 64'(m_func3), 64'(mi.f3));
                if (mi.own_d) check("m_wdata", 64'(m_wdata), 64'(mi.wdata));
            end
            e_ir = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc) && !rsp_q[0].own_d;
            e_dr = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc) && rsp_q[0].own_d;
            check("if_ready", 64'(if_ready), 64'(e_ir));
            check("d_ready", 64'(d_ready), 64'(e_dr));
            if (e_ir || e_dr) begin
                mr = rsp_q.pop_front();
                if (!mr.own_d) exp_if_rdata = mr.data;
                else if (mr.is_st) d_known = 1'b0;
                else begin
                    exp_d_rdata = mr.data;
                    d_known     = 1'b1;
                end
            end
            if (if_ready) log_q.push_back(1'b0);
            if (d_ready) log_q.push_back(1'b1);
            check("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
            if (d_known) check("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
            check("stall_if", 64'(stall_if), 64'(if_req & ~e_ir));
            check("stall_mem", 64'(stall_mem), 64'((d_req_rd | d_req_wr) & ~e_dr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a]    = v;
        shadow[a] = v;
    endtask

    task automatic fetch(input logic [31:0] a, output int tr, output logic [31:0] rdv);
        bit seen = 1'b0;
        if_req  = 1'b1;
        if_addr = a;
        tr      = -1;
        rdv     = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (if_ready) begin
                seen = 1'b1;
                tr   = cyc;
                rdv  = if_rdata;
                break;
            end
        end
        check("if_ready_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic dacc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output int tr, output logic [31:0] rdv,
                        output logic we_seen);
        bit seen = 1'b0;
        d_req_rd = rd;
        d_req_wr = wr;
        d_addr   = a;
        d_wdata  = wd;
        d_func3  = f3;
        we_seen  = 1'b0;
        tr       = -1;
        rdv      = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (m_en) we_seen = m_we;
            if (d_ready) begin
                seen = 1'b1;
                tr   = cyc;
                rdv  = d_rdata;
                break;
            end
        end
        check("d_ready_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        d_req_rd = 1'b0;
        d_req_wr = 1'b0;
    endtask

    task automatic rand_fetch_agent(input int n);
        int hold;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            if_req  = 1'b1;
            if_addr = 32'($urandom_range(0, 15)) << 2;
            hold    = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 64;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (if_ready) break;
            end
            @(posedge clk);
            #1;
            if_req = 1'b0;
        end
    endtask

    task automatic rand_data_agent(input int n);
        int hold, op;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            op       = $urandom_range(0, 3);
            d_req_rd = (op != 2);
            d_req_wr = (op >= 2);
            d_addr   = 32'($urandom_range(0, 15)) << 2;
            d_wdata  = $urandom;
            d_func3  = 3'($urandom_range(0, 5));
            hold     = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 64;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (d_ready) break;
            end
            @(posedge clk);
            #1;
            d_req_rd = 1'b0;
            d_req_wr = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: bench did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin : main
        int          t0, tf, td, tr;
        logic [31:0] rdv;
        logic        wes;
        logic [5:0]  got;
        bit          seen;

        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        d_req_rd = 1'b0;
        d_req_wr = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        d_func3  = '0;
        preload(32'h10, 32'h0050_0093);
        idle(3);
        rst = 1'b0;

        // single fetch
        t0 = cyc;
        fetch(32'h10, tr, rdv);
        check("fetch_latency", 64'(tr - t0), 64'(LAT + 2));
        check("fetch_data", 64'(rdv), 64'(32'h0050_0093));
        idle(2);

        // store then load on the same address
        dacc(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010, tr, rdv, wes);
        check("store_we", 64'(wes), 64'(1));
        dacc(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, tr, rdv, wes);
        check("load_we", 64'(wes), 64'(0));
        check("load_after_store", 64'(rdv), 64'(32'hDEAD_BEEF));
        idle(2);

        // simultaneous fetch and load
        t0 = cyc;
        fork
            fetch(32'h14, tf, rdv);
            dacc(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, td, rdv, wes);
        join
        check("simul_d_ready", 64'(td - t0), 64'(4));
        check("simul_if_ready", 64'(tf - t0), 64'(9));
        idle(2);

        // starvation limit with both requesters held
        log_q.delete();
        fork
            begin
                for (int k = 0; k < 4; k++)
                    dacc(1'b1, 1'b0, 32'h80 + 32'(k * 4), 32'h0, 3'b010, td, rdv, wes);
            end
            begin
                for (int k = 0; k < 2; k++) fetch(32'h100 + 32'(k * 4), tf, rdv);
            end
        join
        got = '0;
        for (int k = 0; k < log_q.size() && k < 6; k++) got[5-k] = log_q[k];
        check("starve_count", 64'(log_q.size()), 64'(6));
        check("starve_order", 64'(got), 64'(6'b110110));
        idle(2);

        // load and store both high behaves as a store
        dacc(1'b1, 1'b1, 32'h48, 32'h1234_5678, 3'b010, tr, rdv, wes);
        check("both_is_store", 64'(wes), 64'(1));
        dacc(1'b1, 1'b0, 32'h48, 32'h0, 3'b010, tr, rdv, wes);
        check("both_load_back", 64'(rdv), 64'(32'h1234_5678));
        idle(3);

        // reset while a fetch is waiting on memory
        if_req  = 1'b1;
        if_addr = 32'h20;
        seen    = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (m_en) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_pre_issue", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst  = 1'b0;
        t0   = cyc;
        tr   = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (m_en) begin
                tr = cyc;
                break;
            end
        end
        check("post_reset_men", 64'(tr - t0), 64'(1));
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (if_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("post_reset_ready", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        if_req = 1'b0;
        idle(3);

        // randomized traffic from both requesters
        fork
            rand_fetch_agent(40);
            rand_data_agent(40);
        join
        idle(12);
        check("sb_drained", 64'(iss_q.size() + rsp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
